// File: rtl/rtp_pkg.sv
// Shared RTP receive constants, state encodings and helpers.
// Also the source of the default PT/SSRC values used by net_top.
package rtp_pkg;

    localparam int unsigned RTP_HDR_LEN      = 12;
    localparam logic [1:0]  RTP_VERSION      = 2'd2;
    localparam logic [6:0]  RTP_PT_DEFAULT   = 7'd0;
    localparam logic [31:0] RTP_SSRC_DEFAULT = 32'h12345678;

    typedef enum logic [1:0] {R_IDLE, R_HDR, R_PAY, R_DROP} rx_state_e;
    typedef enum logic {P_BUF, P_PLAY} play_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rtp_sample_fifo.sv
// Simple dual-port sample RAM with a registered read port.
// Pointer commit/rollback is handled by the parent.
module rtp_sample_fifo #(
    parameter int unsigned Depth = 2048
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(Depth)-1:0] wr_addr_i,
    input  logic [15:0]              wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(Depth)-1:0] rd_addr_i,
    output logic [15:0]              rd_data_o
);

    logic [15:0] mem_q [Depth];
    logic [15:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rtp_rx_depacketizer.sv
// RTP/UDP receive depacketizer feeding a committed-sample jitter FIFO for the wav play path.
// Define RTP_SSRC_CHECK_EN to also require the captured SSRC to match the SSRC parameter.
module rtp_rx_depacketizer
    import rtp_pkg::*;
#(
    parameter logic [6:0]  RTP_PT     = RTP_PT_DEFAULT,
    parameter logic [31:0] SSRC       = RTP_SSRC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned PREFILL    = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          udp_rec_data_valid,
    input  logic [7:0]                    udp_rec_rdata,
    input  logic [15:0]                   udp_rec_data_length,
    input  logic                          wav_rden,
    output logic [15:0]                   wav_out_data,
    output logic                          playing,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   pkt_ok_cnt,
    output logic [15:0]                   pkt_drop_cnt,
    output logic [15:0]                   seq_gap_cnt,
    output logic [15:0]                   underrun_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] DEPTH_W   = LW'(FIFO_DEPTH);
    localparam logic [AW:0] PREFILL_W = LW'(PREFILL);

    rx_state_e   rx_q;
    play_state_e p_q;
    logic [15:0] bcnt_q, len_q, seq_q, last_seq_q;
    logic [1:0]  ver_q;
    logic [6:0]  pt_q;
    logic [7:0]  hi_q;
    logic        seq_vld_q, zero_q;
    logic [AW:0] wr_tmp_q, wr_cmt_q, rd_ptr_q;
    logic [15:0] ok_q, drop_q, gap_q, under_q;

    logic [15:0] pay_bytes, free_w;
    logic [AW:0] free;
    logic        accept, wr_en, rd_en;
    logic [15:0] rd_data;

`ifdef RTP_SSRC_CHECK_EN
    logic [23:0] ssrc_q;
`else
    logic unused_ssrc;
    assign unused_ssrc = ^SSRC;
`endif

    assign fifo_level = wr_cmt_q - rd_ptr_q;
    assign free       = DEPTH_W - fifo_level;
    assign free_w     = 16'(free);
    assign pay_bytes  = len_q - 16'(RTP_HDR_LEN);

    // Evaluated while the last header byte (bcnt 11) is on the bus.
    always_comb begin
        accept = (ver_q == RTP_VERSION) && (pt_q == RTP_PT) && (len_q >= 16'd14) &&
                 !pay_bytes[0] && ({1'b0, pay_bytes[15:1]} <= free_w);
`ifdef RTP_SSRC_CHECK_EN
        accept = accept && ({ssrc_q, udp_rec_rdata} == SSRC);
`endif
    end

    assign wr_en = (rx_q == R_PAY) && udp_rec_data_valid && bcnt_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q       <= R_IDLE;
            bcnt_q     <= '0;
            len_q      <= '0;
            ver_q      <= '0;
            pt_q       <= '0;
            seq_q      <= '0;
            last_seq_q <= '0;
            seq_vld_q  <= 1'b0;
            hi_q       <= '0;
            wr_tmp_q   <= '0;
            wr_cmt_q   <= '0;
            ok_q       <= '0;
            drop_q     <= '0;
            gap_q      <= '0;
`ifdef RTP_SSRC_CHECK_EN
            ssrc_q     <= '0;
`endif
        end else begin
            unique case (rx_q)
                R_IDLE: begin
                    if (udp_rec_data_valid) begin
                        len_q  <= udp_rec_data_length;
                        ver_q  <= udp_rec_rdata[7:6];
                        bcnt_q <= 16'd1;
                        if (udp_rec_data_length < 16'd2) begin
                            drop_q <= sat_inc(drop_q);
                        end else begin
                            rx_q <= R_HDR;
                        end
                    end
                end
                R_HDR: begin
                    if (!udp_rec_data_valid) begin
                        drop_q   <= sat_inc(drop_q);
                        wr_tmp_q <= wr_cmt_q;
                        rx_q     <= R_IDLE;
                    end else begin
                        bcnt_q <= bcnt_q + 16'd1;
                        case (bcnt_q)
                            16'd1: pt_q <= udp_rec_rdata[6:0];
                            16'd2: seq_q[15:8] <= udp_rec_rdata;
                            16'd3: seq_q[7:0] <= udp_rec_rdata;
`ifdef RTP_SSRC_CHECK_EN
                            16'd8:  ssrc_q[23:16] <= udp_rec_rdata;
                            16'd9:  ssrc_q[15:8]  <= udp_rec_rdata;
                            16'd10: ssrc_q[7:0]   <= udp_rec_rdata;
`endif
                            default: ;
                        endcase
                        if (bcnt_q == 16'd11) begin
                            if (accept) begin
                                rx_q <= R_PAY;
                            end else begin
                                drop_q <= sat_inc(drop_q);
                                rx_q   <= (bcnt_q == len_q - 16'd1) ? R_IDLE : R_DROP;
                            end
                        end else if (bcnt_q == len_q - 16'd1) begin
                            // Packet shorter than an RTP header.
                            drop_q <= sat_inc(drop_q);
                            rx_q   <= R_IDLE;
                        end
                    end
                end
                R_PAY: begin
                    if (!udp_rec_data_valid) begin
                        drop_q   <= sat_inc(drop_q);
                        wr_tmp_q <= wr_cmt_q;
                        rx_q     <= R_IDLE;
                    end else begin
                        bcnt_q <= bcnt_q + 16'd1;
                        if (!bcnt_q[0]) begin
                            hi_q <= udp_rec_rdata;
                        end else begin
                            wr_tmp_q <= wr_tmp_q + 1'b1;
                        end
                        if (bcnt_q == len_q - 16'd1) begin
                            wr_cmt_q   <= wr_tmp_q + 1'b1;
                            ok_q       <= sat_inc(ok_q);
                            last_seq_q <= seq_q;
                            seq_vld_q  <= 1'b1;
                            if (seq_vld_q && (seq_q != last_seq_q + 16'd1)) begin
                                gap_q <= sat_inc(gap_q);
                            end
                            rx_q <= R_IDLE;
                        end
                    end
                end
                R_DROP: begin
                    if (!udp_rec_data_valid || (bcnt_q == len_q - 16'd1)) begin
                        rx_q <= R_IDLE;
                    end else begin
                        bcnt_q <= bcnt_q + 16'd1;
                    end
                end
                default: rx_q <= R_IDLE;
            endcase
        end
    end

    assign rd_en = (p_q == P_PLAY) && wav_rden && (fifo_level != '0);

    // zero_q masks the RAM read register whenever a request must return silence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q      <= P_BUF;
            rd_ptr_q <= '0;
            zero_q   <= 1'b1;
            under_q  <= '0;
        end else begin
            unique case (p_q)
                P_BUF: begin
                    if (wav_rden) begin
                        zero_q <= 1'b1;
                    end
                    if (fifo_level >= PREFILL_W) begin
                        p_q <= P_PLAY;
                    end
                end
                P_PLAY: begin
                    if (wav_rden) begin
                        if (fifo_level != '0) begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                            zero_q   <= 1'b0;
                        end else begin
                            zero_q  <= 1'b1;
                            under_q <= sat_inc(under_q);
                            p_q     <= P_BUF;
                        end
                    end
                end
                default: p_q <= P_BUF;
            endcase
        end
    end

    rtp_sample_fifo #(
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .rst_i    (rst),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_tmp_q[AW-1:0]),
        .wr_data_i({hi_q, udp_rec_rdata}),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_ptr_q[AW-1:0]),
        .rd_data_o(rd_data)
    );

    assign wav_out_data = zero_q ? 16'd0 : rd_data;
    assign playing      = (p_q == P_PLAY);
    assign pkt_ok_cnt   = ok_q;
    assign pkt_drop_cnt = drop_q;
    assign seq_gap_cnt  = gap_q;
    assign underrun_cnt = under_q;

endmodule

// File: tb/tb_rtp_rx_depacketizer.sv
// Self-checking bench: directed and randomized packets against a packet-level queue model.
module tb_rtp_rx_depacketizer;

    localparam int          DEPTH   = 2048;
    localparam int          PREFILL = 512;
    localparam logic [6:0]  PT      = 7'd0;
    localparam logic [31:0] SSRC    = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  rdata = '0;
    logic [15:0] length = '0;
    logic        rden = 1'b0;
    logic [15:0] wav_out_data;
    logic        playing;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, underrun_cnt;

    rtp_rx_depacketizer #(
        .RTP_PT    (PT),
        .SSRC      (SSRC),
        .FIFO_DEPTH(DEPTH),
        .PREFILL   (PREFILL)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .udp_rec_data_valid (valid),
        .udp_rec_rdata      (rdata),
        .udp_rec_data_length(length),
        .wav_rden           (rden),
        .wav_out_data       (wav_out_data),
        .playing            (playing),
        .fifo_level         (fifo_level),
        .pkt_ok_cnt         (pkt_ok_cnt),
        .pkt_drop_cnt       (pkt_drop_cnt),
        .seq_gap_cnt        (seq_gap_cnt),
        .underrun_cnt       (underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: committed samples in order, plus packet-level counters.
    logic [15:0] mq[$];
    int          m_ok, m_drop, m_gap, m_under;
    bit          m_play, m_lvld;
    logic [15:0] m_last;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ok = 0; m_drop = 0; m_gap = 0; m_under = 0;
        m_play = 0; m_lvld = 0; m_last = '0;
    endtask

    task automatic check_state();
        chk("pkt_ok_cnt", {16'd0, pkt_ok_cnt}, m_ok);
        chk("pkt_drop_cnt", {16'd0, pkt_drop_cnt}, m_drop);
        chk("seq_gap_cnt", {16'd0, seq_gap_cnt}, m_gap);
        chk("underrun_cnt", {16'd0, underrun_cnt}, m_under);
        chk("fifo_level", 32'(fifo_level), mq.size());
        chk("playing", 32'(playing), 32'(m_play));
    endtask

    // cut = bytes actually sent; do_rst asserts reset asynchronously after those bytes.
    task automatic send_pkt(input int len, input logic [7:0] b0, input logic [6:0] pt,
                            input logic [15:0] seq, input logic [31:0] ssrc,
                            input int cut, input bit do_rst);
        logic [7:0]  pkt[$];
        logic [15:0] nxt;
        bit          acc;
        pkt.push_back(b0);
        pkt.push_back({1'($urandom), pt});
        pkt.push_back(seq[15:8]);
        pkt.push_back(seq[7:0]);
        for (int i = 0; i < 4; i++) pkt.push_back(8'($urandom));
        pkt.push_back(ssrc[31:24]);
        pkt.push_back(ssrc[23:16]);
        pkt.push_back(ssrc[15:8]);
        pkt.push_back(ssrc[7:0]);
        for (int i = 12; i < len; i++) pkt.push_back(8'($urandom));

        acc = (b0[7:6] == 2'd2) && (pt == PT) && (len >= 14) && (len % 2 == 0) &&
              ((len - 12) / 2 <= DEPTH - mq.size());
`ifdef RTP_SSRC_CHECK_EN
        acc = acc && (ssrc == SSRC);
`endif

        for (int i = 0; i < cut; i++) begin
            valid = 1'b1;
            rdata = pkt[i];
            length = 16'(len);
            tick();
        end

        if (do_rst) begin
            #2 rst = 1'b1;
            #1;
            model_reset();
            check_state();
            chk("rst_wav_out_data", {16'd0, wav_out_data}, 0);
            valid = 1'b0;
            tick();
            rst = 1'b0;
            tick();
            return;
        end

        valid = 1'b0;
        rdata = '0;
        repeat (4) tick();

        if (cut < 12 || !acc || cut < len) begin
            m_drop++;
        end else begin
            for (int k = 0; k < (len - 12) / 2; k++) mq.push_back({pkt[12 + 2 * k], pkt[13 + 2 * k]});
            m_ok++;
            nxt = m_last + 16'd1;
            if (m_lvld && seq != nxt) m_gap++;
            m_last = seq;
            m_lvld = 1;
        end
        if (!m_play && mq.size() >= PREFILL) m_play = 1;
        check_state();
    endtask

    task automatic do_read();
        logic [15:0] exp;
        rden = 1'b1;
        tick();
        rden = 1'b0;
        if (!m_play) begin
            exp = '0;
        end else if (mq.size() > 0) begin
            exp = mq.pop_front();
        end else begin
            exp = '0;
            m_under++;
            m_play = 0;
        end
        chk("wav_out_data", {16'd0, wav_out_data}, exp);
        tick();
    endtask

    initial begin
        logic [15:0] nseq;
        int len, cut, free;

        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_state();
        chk("reset_wav_out_data", {16'd0, wav_out_data}, 0);

        // First packet fills below prefill; a request in buffering returns silence.
        send_pkt(960, 8'h80, PT, 16'd5, SSRC, 960, 0);
        do_read();
        send_pkt(960, 8'h80, PT, 16'd6, SSRC, 960, 0);
        for (int k = 0; k < 8; k++) do_read();

        // Wrong version, then a normal packet, then a truncated one.
        send_pkt(960, 8'h40, PT, 16'd7, SSRC, 960, 0);
        send_pkt(960, 8'h80, PT, 16'd7, SSRC, 960, 0);
        send_pkt(960, 8'h80, PT, 16'd8, SSRC, 100, 0);
        for (int k = 0; k < 4; k++) do_read();

        // Sequence wrap is continuous, skipping 1 is a gap.
        send_pkt(112, 8'h80, PT, 16'hFFFF, SSRC, 112, 0);
        send_pkt(112, 8'h80, PT, 16'h0000, SSRC, 112, 0);
        send_pkt(112, 8'h80, PT, 16'h0002, SSRC, 112, 0);

        // Payload type mismatch and foreign SSRC.
        send_pkt(112, 8'h80, 7'd3, 16'h0003, SSRC, 112, 0);
        send_pkt(112, 8'h80, PT, 16'h0003, 32'hDEADBEEF, 112, 0);
        nseq = m_last + 16'd1;

        // Fill to the brim: too-large packet rejected, exact fit accepted, then full.
        for (int k = 0; k < 6 && (DEPTH - mq.size()) >= 474; k++) begin
            send_pkt(960, 8'h80, PT, nseq, SSRC, 960, 0);
            nseq++;
        end
        send_pkt(960, 8'h80, PT, nseq, SSRC, 960, 0);
        free = DEPTH - mq.size();
        if (free > 0) begin
            send_pkt(12 + 2 * free, 8'h80, PT, nseq, SSRC, 12 + 2 * free, 0);
            nseq++;
        end
        send_pkt(14, 8'h80, PT, nseq, SSRC, 14, 0);

        // Drain completely, then one request too many.
        for (int k = 0; k < DEPTH + 8 && mq.size() > 0 && m_play; k++) do_read();
        do_read();
        check_state();

        // Odd payload and header-only packets are dropped.
        send_pkt(961, 8'h80, PT, nseq, SSRC, 961, 0);
        send_pkt(12, 8'h80, PT, nseq, SSRC, 12, 0);

        for (int it = 0; it < 12; it++) begin
            len = 14 + 2 * int'($urandom_range(0, 300));
            cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : len;
            send_pkt(len, 8'h80, PT, nseq, SSRC, cut, 0);
            nseq = nseq + 16'(1 + ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 40)) do_read();
        end

        // Reset in the middle of a packet, then normal operation again.
        send_pkt(960, 8'h80, PT, nseq, SSRC, 300, 1);
        send_pkt(960, 8'h80, PT, 16'd20, SSRC, 960, 0);
        send_pkt(960, 8'h80, PT, 16'd21, SSRC, 960, 0);
        for (int k = 0; k < 4; k++) do_read();
        check_state();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtp_rx_depacketizer.md
Name: rtp_rx_depacketizer

Overview:
- Receive-side counterpart of the audio RTP/UDP packetizer. Takes the UDP receive byte stream from ethernet_test and validates the 12-byte RTP header.
- Buffers the 16-bit PCM payload in a jitter FIFO and supplies samples to mywav on its wav_rden/wav_out_data play interface.
- Sits between ethernet_test (udp_rec_*) and mywav (play path), in the 50 MHz clk domain.

Parameters:
- RTP_PT, 7'd0, expected RTP payload type.
- SSRC, 32'h12345678, expected sender SSRC; used only with the optional feature.
- FIFO_DEPTH, 2048, sample FIFO depth in 16-bit words; must be a power of two.
- PREFILL, 512, committed samples required before playback starts or resumes.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-high reset
- udp_rec_data_valid  in  1  one payload byte per cycle while high; a packet arrives as one contiguous run
- udp_rec_rdata  in  8  UDP payload byte, network order
- udp_rec_data_length  in  16  UDP payload length in bytes; sampled on the first valid byte
- wav_rden  in  1  single-cycle sample request from mywav
- wav_out_data  out  16  sample to DAC; held between requests
- playing  out  1  high while in PLAY
- fifo_level  out  $clog2(FIFO_DEPTH)+1  committed samples held
- pkt_ok_cnt  out  16  packets accepted, saturating
- pkt_drop_cnt  out  16  packets rejected or aborted, saturating
- seq_gap_cnt  out  16  sequence discontinuities, saturating
- underrun_cnt  out  16  requests that found the FIFO empty while in PLAY, saturating

Behaviour:
- Reset: every output is 0. Pointers are 0, both FSMs go to idle, and the last-seq-valid flag is cleared.
- Rx FSM states: R_IDLE, R_HDR, R_PAY, R_DROP. A byte counter bcnt[15:0] counts from 0; len is latched on the first byte.
- R_IDLE -> R_HDR on valid; byte 0 is captured as bcnt=0.
- R_HDR:
  - Capture byte0 (V/P/X/CC), byte1 (M/PT), bytes 2-3 (seq, big-endian), bytes 8-11 (SSRC). Bytes 4-7 (timestamp) are ignored.
  - At bcnt=11 evaluate accept = V==2 and PT==RTP_PT and len>=14 and (len-12) even and (len-12)/2 <= free space. free = FIFO_DEPTH - fifo_level, evaluated in that cycle.
  - Accept -> R_PAY. Reject -> R_DROP and increment pkt_drop_cnt.
- R_PAY:
  - Byte pairs form one sample, high byte first.
  - Each sample is written at a tentative pointer wr_tmp. The committed pointer wr_cmt does not move.
  - On the last byte (bcnt==len-1): wr_cmt<=wr_tmp+1, pkt_ok_cnt++, sequence check, then -> R_IDLE.
- R_DROP: consume bytes until bcnt==len-1 or valid low, then -> R_IDLE.
- Valid low in R_HDR or R_PAY before len bytes:
  - Abort and increment pkt_drop_cnt.
  - wr_tmp<=wr_cmt, which rolls back the partial payload. -> R_IDLE.
- Sequence check on accept: if the last-seq-valid flag is set and seq != last_seq+1 (mod 2^16), seq_gap_cnt++. Then last_seq<=seq and the flag is set. 0xFFFF -> 0x0000 is not a gap.
- Play FSM states: P_BUF, P_PLAY.
  - P_BUF -> P_PLAY when fifo_level>=PREFILL.
  - In P_BUF, wav_rden loads wav_out_data<=0 and pops nothing.
  - In P_PLAY, wav_rden with fifo_level>0 loads the sample at rd_ptr on the next edge (latency 1 cycle) and advances rd_ptr.
  - In P_PLAY, wav_rden with fifo_level==0 loads 0, increments underrun_cnt, and goes -> P_BUF.
- fifo_level = wr_cmt - rd_ptr, using pointers one bit wider than the address. Pointers wrap naturally.
- A commit and a pop in the same cycle both take effect.
- Counters stick at 16'hFFFF.
- The reader never sees uncommitted data.
- Reset asserted mid-packet or mid-play clears everything immediately, asynchronously.

Optional Feature:
- Macro: RTP_SSRC_CHECK_EN.
- Defined: the accept condition additionally requires the captured SSRC == SSRC. A mismatch drops the packet and does not update last_seq.
- Undefined: SSRC bytes are not compared and SSRC capture registers are not synthesized.

Decomposition:
- Shared package rtp_pkg:
  - RTP_HDR_LEN=12 and RTP_VERSION=2.
  - Rx and play state encodings.
  - Default SSRC and PT constants, shared with net_top.
- One sub-module, rtp_sample_fifo:
  - Simple dual-port RAM with separate write (wr_tmp) and read pointer ports.
  - Registered read.
  - Commit/rollback logic stays in the parent.

Test Plan:
- Valid packet, len=960 (474 samples), V=2, PT=0, seq=5 -> pkt_ok_cnt=1, fifo_level=474, playing=0.
- Second packet seq=6, then wav_rden pulses -> playing=1. First wav_out_data equals bytes 12-13 of packet 1, one cycle after wav_rden.
- Packet byte0=8'h40 (V=1) -> pkt_drop_cnt=1, fifo_level unchanged. Next valid packet is accepted normally.
- Valid deasserted after byte 100 of a len=960 packet -> pkt_drop_cnt++, fifo_level unchanged, no partial samples played.
- Packets seq=0xFFFF, 0x0000, 0x0002 -> seq_gap_cnt=1.
- Drain FIFO in P_PLAY then one extra wav_rden -> wav_out_data=0, underrun_cnt=1, playing=0. Odd payload len=961 -> dropped.
